// File: rtl/gf180mcu_prbs_pkg.sv
// Shared definitions for the gf180mcu XNOR-feedback PRBS generator/checker pair.
// Holds the checker state encoding, standard polynomials and the feedback function.
package gf180mcu_prbs_pkg;

  typedef enum logic [1:0] {
    HUNT_FILL,
    HUNT_MATCH,
    LOCKED
  } prbs_state_e;

  // Standard polynomials x^W + x^T + 1
  localparam int unsigned PRBS7_WIDTH  = 7;
  localparam int unsigned PRBS7_TAP    = 6;
  localparam int unsigned PRBS9_WIDTH  = 9;
  localparam int unsigned PRBS9_TAP    = 5;
  localparam int unsigned PRBS15_WIDTH = 15;
  localparam int unsigned PRBS15_TAP   = 14;
  localparam int unsigned PRBS23_WIDTH = 23;
  localparam int unsigned PRBS23_TAP   = 18;
  localparam int unsigned PRBS31_WIDTH = 31;
  localparam int unsigned PRBS31_TAP   = 28;

  // XNOR prediction; all-ones is the lockup state, all-zero is legal
  function automatic logic next_bit(input logic [31:0] s,
                                    input int unsigned width,
                                    input int unsigned tap);
    return ~(s[width-1] ^ s[tap-1]);
  endfunction

endpackage

// File: rtl/gf180mcu_prbs_lfsr.sv
// PRBS shift register shared by generator and checker: shifts in D when loading,
// otherwise its own XNOR feedback; holds when EN is low.
module gf180mcu_prbs_lfsr
  import gf180mcu_prbs_pkg::*;
#(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned TAP   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             d,
  output logic [WIDTH-1:0] s,
  output logic             pred
);

  assign pred = next_bit(32'(s), WIDTH, TAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else if (en) begin
      s <= {s[WIDTH-2:0], load ? d : pred};
    end
  end

endmodule

// File: rtl/gf180mcu_prbs_chk.sv
// Serial PRBS checker: self-seeds from D, locks after LOCK_CNT correct predictions,
// then free-runs to flag/count bit errors and relocks on burst errors.
module gf180mcu_prbs_chk #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned TAP      = 6,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned WIN      = 64,
  parameter int unsigned LOSS_THR = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             D,
  input  logic             CLR,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT
);
  import gf180mcu_prbs_pkg::*;

  localparam int unsigned FW = $clog2(WIDTH);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(WIN);
  localparam int unsigned EW = $clog2(LOSS_THR + 1);

  prbs_state_e     state, state_d;
  logic [FW-1:0]   fill_cnt, fill_d;
  logic [MW-1:0]   match_cnt, match_d;
  logic [WW-1:0]   win_cnt, wcnt_d;
  logic [EW-1:0]   win_err, werr_d, werr_sum;
  logic            err_d;
  logic [WIDTH-1:0] s;
  logic            pred;

  gf180mcu_prbs_lfsr #(
    .WIDTH (WIDTH),
    .TAP   (TAP)
  ) u_lfsr (
    .clk  (CLK),
    .rst  (RST),
    .en   (EN),
    .load (state != gf180mcu_prbs_pkg::LOCKED),
    .d    (D),
    .s    (s),
    .pred (pred)
  );

  assign LOCKED = (state == gf180mcu_prbs_pkg::LOCKED);

  always_comb begin
    state_d  = state;
    fill_d   = fill_cnt;
    match_d  = match_cnt;
    wcnt_d   = win_cnt;
    werr_d   = win_err;
    werr_sum = win_err;
    err_d    = 1'b0;
    if (EN) begin
      unique case (state)
        HUNT_FILL: begin
          match_d = '0;
          if (fill_cnt == FW'(WIDTH - 1)) begin
            fill_d  = '0;
            state_d = HUNT_MATCH;
          end else begin
            fill_d = fill_cnt + FW'(1);
          end
        end
        HUNT_MATCH: begin
          if (D == pred && s != '1) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              match_d = '0;
              wcnt_d  = '0;
              werr_d  = '0;
              state_d = gf180mcu_prbs_pkg::LOCKED;
            end else begin
              match_d = match_cnt + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        gf180mcu_prbs_pkg::LOCKED: begin
          err_d    = (D != pred);
          werr_sum = win_err + EW'(err_d);
          // Threshold is tested before the window rollover, so an error on the
          // last cycle of a window still counts toward loss of lock.
          if (werr_sum == EW'(LOSS_THR)) begin
            state_d = HUNT_FILL;
            fill_d  = '0;
            wcnt_d  = '0;
            werr_d  = '0;
          end else if (win_cnt == WW'(WIN - 1)) begin
            wcnt_d = '0;
            werr_d = '0;
          end else begin
            wcnt_d = win_cnt + WW'(1);
            werr_d = werr_sum;
          end
        end
        default: state_d = HUNT_FILL;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HUNT_FILL;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      ERR       <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      state     <= state_d;
      fill_cnt  <= fill_d;
      match_cnt <= match_d;
      win_cnt   <= wcnt_d;
      win_err   <= werr_d;
      ERR       <= err_d;
      if (CLR) begin
        ERR_CNT <= '0;
      end else if (err_d && ERR_CNT != '1) begin
        ERR_CNT <= ERR_CNT + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_prbs_chk.sv
// Self-checking bench for gf180mcu_prbs_chk: scripted timing scenarios plus a
// randomized EN/CLR/error run against a behavioural bit-history model.
module tb_gf180mcu_prbs_chk;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        d   = 1'b0;
  logic        clr = 1'b0;
  logic        locked_a, err_a;
  logic [15:0] cnt_a;
  logic        locked_b, err_b;
  logic [3:0]  cnt_b;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [6:0] g = '0;

  int m_mode;
  bit m_hist[$];
  int m_fill, m_match, m_wc, m_we, m_cnt;
  bit m_err;

  gf180mcu_prbs_chk dut_a (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .CLR(clr),
    .LOCKED(locked_a), .ERR(err_a), .ERR_CNT(cnt_a)
  );

  gf180mcu_prbs_chk #(.ERR_W(4), .LOSS_THR(64)) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .CLR(clr),
    .LOCKED(locked_b), .ERR(err_b), .ERR_CNT(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic next_gen(output logic b);
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
  endtask

  task automatic tick(input logic e, input logic dd, input logic c);
    en = e; d = dd; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_hist = {};
    repeat (7) m_hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0; m_cnt = 0; m_err = 0;
  endtask

  // Received-bit history, newest first; prediction from the bits 7 and 6 back.
  task automatic model_step(input logic e, input logic dd, input logic c);
    bit p, ones;
    m_err = 0;
    if (e) begin
      p = ~(m_hist[6] ^ m_hist[5]);
      case (m_mode)
        0: begin
          m_hist.push_front(dd); void'(m_hist.pop_back());
          m_fill++;
          if (m_fill == 7) begin m_mode = 1; m_fill = 0; end
        end
        1: begin
          ones = 1;
          foreach (m_hist[k]) if (!m_hist[k]) ones = 0;
          if (dd == p && !ones) begin
            m_match++;
            if (m_match == 8) begin m_mode = 2; m_match = 0; m_wc = 0; m_we = 0; end
          end else m_match = 0;
          m_hist.push_front(dd); void'(m_hist.pop_back());
        end
        default: begin
          m_hist.push_front(p); void'(m_hist.pop_back());
          m_wc++;
          if (dd != p) begin m_err = 1; m_we++; end
          if (m_we == 4) begin m_mode = 0; m_fill = 0; m_wc = 0; m_we = 0; end
          else if (m_wc == 64) begin m_wc = 0; m_we = 0; end
        end
      endcase
    end
    if (c) m_cnt = 0;
    else if (m_err && m_cnt < 65535) m_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; d = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    g = '0;
    model_reset();
  endtask

  task automatic test_reset();
    logic b;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, i[0], 1'b0);
      n_vec++;
      if ({locked_a, err_a, cnt_a, locked_b, err_b, cnt_b} !== 24'd0) begin
        n_bad++;
        $display("FAIL reset_initial cyc %0d got %h want 0", i,
                 {locked_a, err_a, cnt_a, locked_b, err_b, cnt_b});
      end
    end
    rst = 1'b0; g = '0;
    for (int i = 1; i <= 20; i++) begin
      next_gen(b); tick(1'b1, b, 1'b0);
      n_vec++;
      if (locked_a !== (i >= 15)) begin
        n_bad++; $display("FAIL reset_release bit %0d LOCKED got %b want %b", i, locked_a, i >= 15);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, i[0], i[1]);
      n_vec++;
      if ({locked_a, err_a, cnt_a} !== 18'd0) begin
        n_bad++; $display("FAIL reset_midop cyc %0d got %h want 0", i, {locked_a, err_a, cnt_a});
      end
    end
    rst = 1'b0; g = '0;
    for (int i = 1; i <= 15; i++) begin
      next_gen(b); tick(1'b1, b, 1'b0);
      n_vec++;
      if (locked_a !== (i >= 15)) begin
        n_bad++; $display("FAIL reset_relock bit %0d LOCKED got %b want %b", i, locked_a, i >= 15);
      end
    end
  endtask

  task automatic test_lock_clean();
    logic b;
    logic [17:0] exp;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      next_gen(b); tick(1'b1, b, 1'b0);
      exp = {(i >= 15), 1'b0, 16'd0};
      n_vec++;
      if ({locked_a, err_a, cnt_a} !== exp) begin
        n_bad++; $display("FAIL lock_clean bit %0d got %h want %h", i, {locked_a, err_a, cnt_a}, exp);
      end
    end
  endtask

  task automatic test_single_error();
    logic b;
    logic [17:0] exp;
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      next_gen(b); tick(1'b1, b ^ (i == 200), 1'b0);
      exp = {(i >= 15), (i == 200), 15'd0, (i >= 200)};
      n_vec++;
      if ({locked_a, err_a, cnt_a} !== exp) begin
        n_bad++; $display("FAIL single_err bit %0d got %h want %h", i, {locked_a, err_a, cnt_a}, exp);
      end
    end
  endtask

  task automatic test_burst_loss();
    logic b, e, l;
    int cnt;
    logic [17:0] exp;
    do_reset();
    cnt = 0;
    for (int i = 1; i <= 340; i++) begin
      e = (i inside {100, 110, 120, 130, 150, 160, 170, 250, 265, 273, 274, 275, 276});
      next_gen(b); tick(1'b1, b ^ e, 1'b0);
      if (e) cnt++;
      l = (i >= 15 && i < 130) || (i >= 145);
      exp = {l, e, 16'(cnt)};
      n_vec++;
      if ({locked_a, err_a, cnt_a} !== exp) begin
        n_bad++; $display("FAIL burst_loss bit %0d got %h want %h", i, {locked_a, err_a, cnt_a}, exp);
      end
    end
  endtask

  task automatic test_ones_lockup();
    do_reset();
    for (int i = 1; i <= 500; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_vec++;
      if ({locked_a, err_a, cnt_a} !== 18'd0) begin
        n_bad++; $display("FAIL ones_lockup bit %0d got %h want 0", i, {locked_a, err_a, cnt_a});
      end
    end
  endtask

  task automatic test_saturate_clr();
    logic b;
    logic [5:0] exp;
    do_reset();
    for (int i = 1; i <= 15; i++) begin next_gen(b); tick(1'b1, b, 1'b0); end
    for (int k = 1; k <= 30; k++) begin
      next_gen(b); tick(1'b1, ~b, 1'b0);
      exp = {1'b1, 1'b1, 4'((k > 15) ? 15 : k)};
      n_vec++;
      if ({locked_b, err_b, cnt_b} !== exp) begin
        n_bad++; $display("FAIL saturate k %0d got %h want %h", k, {locked_b, err_b, cnt_b}, exp);
      end
    end
    next_gen(b); tick(1'b1, ~b, 1'b1);
    n_vec++;
    if ({locked_b, err_b, cnt_b} !== 6'b110000) begin
      n_bad++; $display("FAIL clr_on_err got %b want 110000", {locked_b, err_b, cnt_b});
    end
    next_gen(b); tick(1'b1, ~b, 1'b0);
    n_vec++;
    if ({locked_b, err_b, cnt_b} !== 6'b110001) begin
      n_bad++; $display("FAIL count_after_clr got %b want 110001", {locked_b, err_b, cnt_b});
    end
  endtask

  task automatic test_random_en();
    logic b, e, c, dd;
    int nen;
    logic [17:0] exp;
    do_reset();
    nen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      e = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 49) == 0);
      if (e) begin
        next_gen(b); nen++;
        dd = b ^ ((nen > 100) && ($urandom_range(0, 29) == 0));
      end else begin
        dd = 1'($urandom_range(0, 1));
      end
      tick(e, dd, c);
      model_step(e, dd, c);
      exp = {(m_mode == 2), m_err, 16'(m_cnt)};
      n_vec++;
      if ({locked_a, err_a, cnt_a} !== exp) begin
        n_bad++; $display("FAIL random cyc %0d got %h want %h", cyc, {locked_a, err_a, cnt_a}, exp);
      end
      if (nen <= 100) begin
        n_vec++;
        if (locked_a !== (nen >= 15)) begin
          n_bad++; $display("FAIL en_gap_lock cyc %0d en_bits %0d LOCKED got %b want %b",
                            cyc, nen, locked_a, nen >= 15);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_clean();
    test_single_error();
    test_burst_loss();
    test_ones_lockup();
    test_saturate_clr();
    test_random_en();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_prbs_chk.md
# gf180mcu_prbs_chk

Serial PRBS checker: the receive end of the XNOR-feedback LFSR pattern generator used on the gf180mcu 7-track test structures. It self-seeds from the incoming bitstream, declares lock after a run of correct predictions, and then free-runs its LFSR to flag and count bit errors. It also drops lock on burst errors. It sits after the device-under-test output sampler on the characterization chain and feeds the scan-readable error counter.

## Interface
- WIDTH, 7: LFSR length (PRBS order); legal range 3..31.
- TAP, 6: second feedback tap, polynomial x^WIDTH + x^TAP + 1; 1 ≤ TAP < WIDTH.
- LOCK_CNT, 8: consecutive correct predictions required to lock; ≥ 1.
- WIN, 64: loss-of-lock window length in enabled cycles; ≥ 2.
- LOSS_THR, 4: errors within one window that force relock; 1..WIN.
- ERR_W, 16: error counter width.

- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  bit-valid qualifier; D is sampled only when EN=1.
- D  in  1  serial data under test.
- CLR  in  1  synchronous clear of ERR_CNT only.
- LOCKED  out  1  registered lock status.
- ERR  out  1  one-cycle registered error pulse.
- ERR_CNT  out  ERR_W  saturating error count.

## Operation
- Shift register S[WIDTH-1:0], with S[0] holding the newest bit. Prediction: p = ~(S[WIDTH-1] ^ S[TAP-1]) (XNOR feedback). All-zero is a valid state; all-ones is the lockup state.
- States:
  - HUNT_FILL: each EN bit does S <= {S[WIDTH-2:0], D}. After WIDTH bits, go to HUNT_MATCH. The match counter is held at 0.
  - HUNT_MATCH: S shifts in D. If D==p and S is not all-ones, the match counter increments; otherwise it clears to 0. When the increment reaches LOCK_CNT, go to LOCKED.
  - LOCKED: S <= {S[WIDTH-2:0], p}, so the LFSR free-runs and ignores D. D != p is an error.
- On each error:
  - ERR=1 for the next cycle.
  - ERR_CNT increments and saturates at 2^ERR_W−1.
  - The window error counter increments.
- Window counter:
  - Counts EN cycles while in LOCKED.
  - Window error count resets to 0 every WIN cycles.
  - If the window error count reaches LOSS_THR, go to HUNT_FILL. The fill restarts from zero and S is not cleared.
- Errors are counted only in LOCKED; HUNT mismatches never touch ERR/ERR_CNT.
- EN=0: state, S, and all counters hold. ERR=0.
- CLR=1: ERR_CNT <= 0. CLR has priority over a same-cycle error. That error still pulses ERR but is not counted.
- RST: state HUNT_FILL, S=0, all counters 0.

## Timing
- Reset values: LOCKED=0, ERR=0, ERR_CNT=0.
- From a clean stream, LOCKED rises on the clock edge that samples bit WIDTH+LOCK_CNT. It is visible the following cycle: bit 15 for the defaults.
- ERR and the ERR_CNT update become visible one cycle after the errored bit is sampled.
- LOCKED falls in the cycle after the bit that brings the window count to LOSS_THR. That bit's ERR pulse and count are still issued.
- RST asserted mid-operation overrides everything on the same edge, including CLR and errors.
- Zero-latency combinational paths from inputs to outputs are forbidden; all outputs are flop-driven.

## Structure
- Package gf180mcu_prbs_pkg holds:
  - the state enum (HUNT_FILL, HUNT_MATCH, LOCKED);
  - standard polynomial constants: PRBS7 (7,6), PRBS9 (9,5), PRBS15 (15,14), PRBS23 (23,18), PRBS31 (31,28);
  - a function next_bit(S) implementing the XNOR prediction.
- Sub-module gf180mcu_prbs_lfsr contains the shift register with load-from-D versus feedback mux and EN hold. It is shared with the generator so both ends use the same feedback.

## Test plan
- Reset with D toggling and EN=1 → LOCKED=0, ERR=0, ERR_CNT=0 throughout RST; state HUNT_FILL after release.
- Clean PRBS7 stream (reference generator, seed 0, EN=1 continuous) → LOCKED=1 exactly one cycle after bit 15; ERR=0 and ERR_CNT=0 over 1000 bits.
- After lock, invert bit 200 only → single ERR pulse one cycle later, ERR_CNT=1, LOCKED stays 1.
- After lock, invert 4 bits within one 64-cycle window → 4 ERR pulses, ERR_CNT=4, LOCKED=0 after the 4th. Relock 15 clean bits later; 3 errors per window never drop lock.
- D held at 1 for 500 bits → LOCKED never asserts (all-ones lockup rejected); ERR_CNT=0.
- ERR_W=4 with continuous inverted stream after lock plus LOSS_THR=WIN → ERR_CNT saturates at 15. Then:
  - CLR pulsed on an error cycle → ERR=1, ERR_CNT=0.
  - Random EN gaps → lock timing counts EN cycles only.
